// File: rtl/mmul_pkg.sv
// Shared types and elaboration helpers for the streaming
// matrix-vector systolic engine.
package mmul_pkg;

    typedef enum logic [1:0] {
        COMPUTE = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r++;
            t = t >> 1;
        end
        return r;
    endfunction

    // Result lanes must hold a full-width product summed N times.
    function automatic bit rw_legal(input int n, input int dw, input int rw);
        return rw >= 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/mmul_pe.sv
// One weight-stationary processing element: holds a weight,
// forwards the activation right and the updated psum down.
module mmul_pe
    import mmul_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          w_we,
    input  logic [DW-1:0] w_in,
    input  logic          signed_flag,
    input  logic [DW-1:0] x_in,
    input  logic [RW-1:0] psum_in,
    output logic [DW-1:0] x_out,
    output logic [RW-1:0] psum_out
);

    logic [DW-1:0]   w;
    logic [2*DW-1:0] xe;
    logic [2*DW-1:0] we;
    logic [2*DW-1:0] prod;
    logic [RW-1:0]   prod_ext;

    // Extend operands to product width so one multiply serves both modes.
    always_comb begin
        xe       = {{DW{signed_flag & x_in[DW-1]}}, x_in};
        we       = {{DW{signed_flag & w[DW-1]}}, w};
        prod     = xe * we;
        prod_ext = {{(RW-2*DW){signed_flag & prod[2*DW-1]}}, prod};
    end

    // Weight register, written only while loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            w <= '0;
        end else if (w_we) begin
            w <= w_in;
        end
    end

    // Activation and partial-sum pipeline registers, frozen on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out    <= '0;
            psum_out <= '0;
        end else if (en) begin
            x_out    <= x_in;
            psum_out <= psum_in + prod_ext;
        end
    end

endmodule

// File: rtl/mmul_stream_array.sv
// N x N weight-stationary systolic matrix-vector engine with
// AXI-Stream in/out, backpressure stall and drained weight reload.
module mmul_stream_array
    import mmul_pkg::*;
#(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_weight,
    input  logic                         signed_mode,
    input  logic [N*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [N*RESULT_WIDTH-1:0]    m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy
);

    localparam int DW    = DATA_WIDTH;
    localparam int RW    = RESULT_WIDTH;
    localparam int DEPTH = 2 * N;
    localparam int CW    = clog2(N);

    if (!rw_legal(N, DATA_WIDTH, RESULT_WIDTH)) begin : g_bad_rw
        $error("RESULT_WIDTH too small for N and DATA_WIDTH");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] row_cnt;
    logic          sflag;
    logic          stall;
    logic          en;
    logic          drained;
    logic          s_fire;
    logic          cmp_fire;
    logic          ld_fire;
    logic          last_row;

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  lst;
    logic [N*RW-1:0]   col_out;

    logic [DW-1:0] act  [N][N+1];
    logic [RW-1:0] psum [N+1][N];

    assign stall    = m_axis_tvalid & ~m_axis_tready;
    assign en       = ~stall;
    assign drained  = ~(|vld) & ~m_axis_tvalid;
    assign last_row = (row_cnt == CW'(N - 1));
    assign s_fire   = s_axis_tvalid & s_axis_tready;
    assign cmp_fire = s_fire & (state == COMPUTE);
    assign ld_fire  = s_fire & (state == LOAD);

    // Next-state, input ready and busy decode.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        busy          = (state != COMPUTE) | (|vld) | m_axis_tvalid;
        unique case (state)
            COMPUTE: begin
                s_axis_tready = en & ~load_weight;
                if (load_weight) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                s_axis_tready = en;
                if (s_axis_tvalid & en & last_row) begin
                    state_nxt = COMPUTE;
                end
            end
            default: state_nxt = COMPUTE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COMPUTE;
        end else begin
            state <= state_nxt;
        end
    end

    // Weight row counter and arithmetic mode, latched on entry to LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            sflag   <= 1'b0;
        end else if (state == DRAIN && drained) begin
            row_cnt <= '0;
            sflag   <= signed_mode;
        end else if (ld_fire) begin
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end
    end

    // Valid/tlast chain and output register, advancing with the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld           <= '0;
            lst           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (en) begin
            vld           <= {vld[DEPTH-2:0], cmp_fire};
            lst           <= {lst[DEPTH-2:0], cmp_fire & s_axis_tlast};
            m_axis_tvalid <= vld[DEPTH-1];
            m_axis_tlast  <= lst[DEPTH-1];
            m_axis_tdata  <= col_out;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] sr [0:i];

        // Input register plus i skew stages; bubbles enter as zero.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d <= i; d++) begin
                    sr[d] <= '0;
                end
            end else if (en) begin
                sr[0] <= cmp_fire ? s_axis_tdata[i*DW +: DW] : '0;
                for (int d = 1; d <= i; d++) begin
                    sr[d] <= sr[d-1];
                end
            end
        end

        assign act[i][0] = sr[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_top
        assign psum[0][j] = '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mmul_pe #(
                .DW(DW),
                .RW(RW)
            ) u_pe (
                .clk        (clk),
                .reset      (reset),
                .en         (en),
                .w_we       (ld_fire && row_cnt == CW'(i)),
                .w_in       (s_axis_tdata[j*DW +: DW]),
                .signed_flag(sflag),
                .x_in       (act[i][j]),
                .psum_in    (psum[i][j]),
                .x_out      (act[i][j+1]),
                .psum_out   (psum[i+1][j])
            );
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign col_out[j*RW +: RW] = psum[N][j];
        end else begin : g_dly
            logic [RW-1:0] sr [0:D-1];

            // Deskew so every column of a row lands on the same cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < D; d++) begin
                        sr[d] <= '0;
                    end
                end else if (en) begin
                    sr[0] <= psum[N][j];
                    for (int d = 1; d < D; d++) begin
                        sr[d] <= sr[d-1];
                    end
                end
            end

            assign col_out[j*RW +: RW] = sr[D-1];
        end
    end

endmodule

// File: tb/tb_mmul_stream_array.sv
// Directed bench for mmul_stream_array (N=4, 8-bit data,
// 32-bit results) with hand-computed expectations.
module tb_mmul_stream_array;

    logic         clk;
    logic         reset;
    logic         load_weight;
    logic         signed_mode;
    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_outs = 0;
    int n_stall = 0;

    logic [127:0] out_d [$];
    logic         out_l [$];
    int           out_c [$];

    logic         prev_stall = 1'b0;
    logic [127:0] prev_d = '0;
    logic         prev_l = 1'b0;

    localparam logic [127:0] IDENT =
        {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    localparam logic [127:0] IDENT2 =
        {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002};

    mmul_stream_array #(
        .N(4),
        .DATA_WIDTH(8),
        .RESULT_WIDTH(32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_weight  (load_weight),
        .signed_mode  (signed_mode),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] row8(input int a, input int b,
                                         input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [127:0] res4(input int a, input int b,
                                          input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Output monitor: captures beats, checks AXI hold rules on stall.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_hold_v", m_tvalid, 1'b1);
            check("stall_hold_d", m_tdata, prev_d);
            check("stall_hold_l", m_tlast, prev_l);
        end
        if (m_tvalid && !m_tready && !reset) begin
            check("stall_s_ready", s_tready, 1'b0);
            n_stall++;
        end
        if (m_tvalid && m_tready && !reset) begin
            out_d.push_back(m_tdata);
            out_l.push_back(m_tlast);
            out_c.push_back(cyc);
        end
        prev_stall = m_tvalid && !m_tready && !reset;
        prev_d = m_tdata;
        prev_l = m_tlast;
    end

    task automatic clear_outs();
        out_d.delete();
        out_l.delete();
        out_c.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tlast = last;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) check("send_timeout", s_tready, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
    endtask

    task automatic wait_outs(input int n, input string tag);
        int t;
        t = 0;
        while (out_d.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, out_d.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [127:0] w, input logic sm);
        int t;
        t = 0;
        idle();
        signed_mode = sm;
        load_weight = 1'b1;
        @(negedge clk);
        check("ld_req_ready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        load_weight = 1'b0;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            check("drain_busy", busy, 1'b1);
            @(negedge clk);
            t++;
        end
        check("drain_done", s_tready, 1'b1);
        ready_outs = out_d.size();
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            send(w[r*32 +: 32], 1'b0);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        load_weight = 1'b0;
        signed_mode = 1'b0;
        m_tready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tdata", m_tdata, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", s_tready, 1'b1);
        @(posedge clk);
        #1;

        // identity weights, latency
        load_w(IDENT, 1'b0);
        clear_outs();
        send(row8(1, 2, 3, 4), 1'b1);
        idle();
        wait_outs(1, "t1_count");
        check("t1_y", out_d[0], res4(1, 2, 3, 4));
        check("t1_last", out_l[0], 1'b1);
        check("t1_latency", out_c[0] - acc_cyc, 8);

        // all-ones weights, signed then unsigned
        load_w({4{32'hFFFFFFFF}}, 1'b1);
        clear_outs();
        send(row8(1, 2, 3, 4), 1'b0);
        idle();
        wait_outs(1, "t2s_count");
        check("t2_signed", out_d[0], {4{32'hFFFFFFF6}});
        load_w({4{32'hFFFFFFFF}}, 1'b0);
        clear_outs();
        send(row8(1, 2, 3, 4), 1'b0);
        idle();
        wait_outs(1, "t2u_count");
        check("t2_unsigned", out_d[0], {4{32'd2550}});

        // back-to-back stream with tlast on the final row
        load_w(IDENT, 1'b0);
        clear_outs();
        for (int r = 0; r < 16; r++) begin
            send(row8(r, r, r, r), r == 15);
        end
        idle();
        wait_outs(16, "t3_count");
        for (int r = 0; r < 16; r++) begin
            check($sformatf("t3_y%0d", r), out_d[r], res4(r, r, r, r));
            check($sformatf("t3_last%0d", r), out_l[r], r == 15);
        end
        for (int r = 1; r < 16; r++) begin
            check($sformatf("t3_gap%0d", r), out_c[r] - out_c[0], r);
        end

        // 5-cycle downstream stall mid-stream
        clear_outs();
        n_stall = 0;
        fork
            begin
                for (int r = 1; r <= 8; r++) begin
                    send(row8(r, 2 * r, 3 * r, 4 * r), r == 8);
                end
                idle();
            end
            begin
                int t;
                t = 0;
                while (out_d.size() < 2 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        wait_outs(8, "t4_count");
        check("t4_stall_cycles", n_stall, 5);
        for (int r = 1; r <= 8; r++) begin
            check($sformatf("t4_y%0d", r), out_d[r-1],
                  res4(r, 2 * r, 3 * r, 4 * r));
        end
        check("t4_last", out_l[7], 1'b1);

        // reload with three rows in flight
        clear_outs();
        for (int r = 0; r < 3; r++) begin
            send(row8(10 + r, 20 + r, 30 + r, 40 + r), 1'b0);
        end
        load_w(IDENT2, 1'b0);
        check("t5_drained_first", ready_outs, 3);
        send(row8(1, 2, 3, 4), 1'b0);
        idle();
        wait_outs(4, "t5_count");
        for (int r = 0; r < 3; r++) begin
            check($sformatf("t5_old%0d", r), out_d[r],
                  res4(10 + r, 20 + r, 30 + r, 40 + r));
        end
        check("t5_new", out_d[3], res4(2, 4, 6, 8));

        // reset with rows in flight
        clear_outs();
        for (int r = 0; r < 10; r++) begin
            send(row8(7, 7, 7, 7), 1'b0);
        end
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_outs();
        @(negedge clk);
        check("t6_tvalid", m_tvalid, 1'b0);
        check("t6_tdata", m_tdata, '0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", s_tready, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_no_stale", out_d.size(), 0);
        @(posedge clk);
        #1;
        send(row8(5, 5, 5, 5), 1'b1);
        idle();
        wait_outs(1, "t6_count");
        check("t6_zero_w", out_d[0], '0);
        check("t6_last", out_l[0], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
